seven_seg_scan_driver: RTL and testbench

Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display. It generalises the single-nibble hex decoder to a parametrised scanner with a registered digit value, tear-free frame updates, per-digit decimal points, leading-zero blanking and an anti-ghosting guard. It sits between the calculator result register and the board display pins.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seven_seg_scan_driver_if.sv | 25 ++
 rtl/seg_hex_lut.sv | 11 +
 rtl/seven_seg_scan_driver.sv | 104 ++++++++++
 tb/tb_seven_seg_scan_driver.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment constants: active-low glyph table and polarity levels.
// Every segment, decimal-point and anode line in this codebase is active-low.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic       DP_ON     = 1'b0;
  localparam logic       DP_OFF    = 1'b1;
  localparam logic       AN_OFF    = 1'b1;

  // Indexed by hex nibble; bit 6 is segment a, bit 0 is segment g.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Host-side bus of the scan driver: frame data and controls in, display pins out.
// load is a single-cycle strobe with no ready: it is always accepted.
interface seven_seg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                blank_lz;
  logic                enable;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output value, dp_in, load, blank_lz, enable,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  value, dp_in, load, blank_lz, enable,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg_hex_lut.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module seg_hex_lut
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = HEX_GLYPH[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode display scanner with tear-free frame commit,
// leading-zero blanking and an anode-off guard at the start of every digit slot.
module seven_seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  seven_seg_scan_driver_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;
  localparam logic [CW-1:0]     CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]     DIG_LAST = DW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_NONE  = {DIGITS{AN_OFF}};

  logic [CW-1:0]     cnt;
  logic [DW-1:0]     d;
  logic [VW-1:0]     pend_val;
  logic [DIGITS-1:0] pend_dp;
  logic [VW-1:0]     shown_val;
  logic [DIGITS-1:0] shown_dp;

  logic [6:0]        seg_q;
  logic              dp_q;
  logic [DIGITS-1:0] an_q;
  logic              frame_done_q;

  logic       slot_end;
  logic       commit;
  logic       in_guard;
  logic       lead_blank;
  logic [3:0] cur_nib;
  logic [6:0] cur_glyph;

  assign slot_end = (cnt == CNT_LAST);
  assign commit   = slot_end && (d == DIG_LAST);
  assign in_guard = (int'(cnt) < GUARD);
  assign cur_nib  = shown_val[{d, 2'b00} +: 4];

  // Digit d is a leading zero when it and every more significant nibble are 0.
  assign lead_blank = bus.blank_lz && (d != '0) &&
                      ((shown_val >> {d, 2'b00}) == '0);

  seg_hex_lut u_lut (
    .nibble (cur_nib),
    .glyph  (cur_glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      d            <= '0;
      pend_val     <= '0;
      pend_dp      <= '0;
      shown_val    <= '0;
      shown_dp     <= '0;
      seg_q        <= SEG_BLANK;
      dp_q         <= DP_OFF;
      an_q         <= AN_NONE;
      frame_done_q <= 1'b0;
    end else begin
      if (bus.load) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp_in;
      end
      if (!bus.enable) begin
        cnt          <= '0;
        d            <= '0;
        seg_q        <= SEG_BLANK;
        dp_q         <= DP_OFF;
        an_q         <= AN_NONE;
        frame_done_q <= 1'b0;
      end else begin
        seg_q        <= lead_blank ? SEG_BLANK : cur_glyph;
        dp_q         <= shown_dp[d] ? DP_ON : DP_OFF;
        an_q         <= in_guard ? AN_NONE : ~(DIGITS'(1) << d);
        frame_done_q <= commit;
        if (slot_end) begin
          cnt <= '0;
          d   <= (d == DIG_LAST) ? '0 : d + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        // A load landing on the commit edge bypasses pending so it is not lost a frame.
        if (commit) begin
          shown_val <= bus.load ? bus.value : pend_val;
          shown_dp  <= bus.load ? bus.dp_in : pend_dp;
        end
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver (4 digits, 4-cycle slots, 1-cycle guard)
// with a frame-level reference model checked on every cycle.
module tb_seven_seg_scan_driver;

  localparam int DIGITS = 4;
  localparam int RD     = 4;
  localparam int G      = 1;
  localparam int FRAME  = DIGITS * RD;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
  } outs_t;

  localparam outs_t OFF_OUT = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, fd: 1'b0};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  seven_seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  seven_seg_scan_driver #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (RD),
    .GUARD       (G)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_pos;
  logic [15:0] m_pv, m_sv;
  logic [3:0]  m_pdp, m_sdp;
  outs_t       e_out;

  function automatic logic [6:0] glyph_of(logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  // What the pins must show one cycle after the scan sits at frame position pos.
  function automatic outs_t model_out(int pos, logic [15:0] sv, logic [3:0] sdp, logic blz);
    outs_t       o;
    int          digit = pos / RD;
    int          slot  = pos % RD;
    logic [15:0] above = sv >> (4 * digit);
    logic [3:0]  nib   = above[3:0];
    o.an  = (slot < G) ? 4'hF : ~(4'b0001 << digit);
    o.seg = (blz && digit > 0 && above == 16'h0) ? 7'h7F : glyph_of(nib);
    o.dp  = ~sdp[digit];
    o.fd  = (pos == FRAME - 1);
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= 0;
      m_pv  <= '0;
      m_pdp <= '0;
      m_sv  <= '0;
      m_sdp <= '0;
      e_out <= OFF_OUT;
    end else begin
      if (bus.load) begin
        m_pv  <= bus.value;
        m_pdp <= bus.dp_in;
      end
      if (!bus.enable) begin
        m_pos <= 0;
        e_out <= OFF_OUT;
      end else begin
        e_out <= model_out(m_pos, m_sv, m_sdp, bus.blank_lz);
        if (m_pos == FRAME - 1) begin
          m_sv  <= bus.load ? bus.value : m_pv;
          m_sdp <= bus.load ? bus.dp_in : m_pdp;
        end
        m_pos <= (m_pos + 1) % FRAME;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait expired, expected event within budget", name);
  endtask

  logic run_cmp = 1'b0;

  always @(negedge clk) begin
    if (run_cmp) begin
      check("cycle", 16'({bus.seg, bus.dp, bus.an, bus.frame_done}), 16'(e_out));
      check("an_at_most_one", 16'($countones(~bus.an) <= 1), 16'd1);
    end
  end

  logic watch_one = 1'b0;
  logic saw_one   = 1'b0;
  always @(negedge clk) begin
    if (watch_one && bus.an != 4'hF && bus.seg == 7'b1001111) saw_one <= 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_load(logic [15:0] v, logic [3:0] dpv);
    bus.value = v;
    bus.dp_in = dpv;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  task automatic wait_pos(int p);
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (m_pos == p) found = 1;
    end
    if (!found) timeout_fail("wait_pos");
  endtask

  task automatic wait_commit();
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (e_out.fd) found = 1;
    end
    if (!found) timeout_fail("wait_commit");
  endtask

  task automatic check_digit(int k, logic [6:0] exp_seg, logic exp_dp, string name);
    bit         found = 0;
    logic [3:0] sel   = ~(4'b0001 << k);
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (e_out.an == sel) begin
        found = 1;
        check(name, 16'({bus.seg, bus.dp, bus.an}), 16'({exp_seg, exp_dp, sel}));
      end
    end
    if (!found) timeout_fail(name);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int fd_cnt;
    bus.value    = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    bus.enable   = 1'b1;

    #1 rst_n = 1'b0;
    #1;
    check("reset_seg", 16'(bus.seg), 16'h7F);
    check("reset_dp", 16'(bus.dp), 16'd1);
    check("reset_an", 16'(bus.an), 16'hF);
    check("reset_fd", 16'(bus.frame_done), 16'd0);
    run_cmp = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // first scan after reset: guard, then digit 0 on the 2nd edge
    @(negedge clk);
    check("first_edge_an", 16'(bus.an), 16'hF);
    @(negedge clk);
    check("second_edge_an", 16'(bus.an), 16'hE);
    check("second_edge_seg", 16'(bus.seg), 16'h01);
    fd_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      fd_cnt += int'(bus.frame_done);
    end
    check("fd_per_two_frames", 16'(fd_cnt), 16'd2);

    // mid-frame load: current frame still zeros, next frame F,2,A,1
    wait_pos(6);
    drive_load(16'h1A2F, 4'b0100);
    check_digit(3, 7'b0000001, 1'b1, "old_frame_d3");
    check_digit(0, 7'b0111000, 1'b1, "new_d0_F");
    check_digit(1, 7'b0010010, 1'b1, "new_d1_2");
    check_digit(2, 7'b0001000, 1'b0, "new_d2_A_dp");
    check_digit(3, 7'b1001111, 1'b1, "new_d3_1");

    // leading-zero blanking
    bus.blank_lz = 1'b1;
    drive_load(16'h00C0, 4'b0000);
    wait_commit();
    check_digit(0, 7'b0000001, 1'b1, "lz_d0");
    check_digit(1, 7'b0110001, 1'b1, "lz_d1_C");
    check_digit(2, 7'b1111111, 1'b1, "lz_d2_blank");
    check_digit(3, 7'b1111111, 1'b1, "lz_d3_blank");
    drive_load(16'h0000, 4'b0000);
    wait_commit();
    check_digit(0, 7'b0000001, 1'b1, "lz0_d0");
    check_digit(1, 7'b1111111, 1'b1, "lz0_d1");
    check_digit(2, 7'b1111111, 1'b1, "lz0_d2");
    check_digit(3, 7'b1111111, 1'b1, "lz0_d3");
    bus.blank_lz = 1'b0;

    // two loads in one frame: last wins; load on commit edge shows next frame
    wait_commit();
    watch_one = 1'b1;
    drive_load(16'h1111, 4'b0000);
    @(negedge clk);
    drive_load(16'h2222, 4'b0000);
    wait_commit();
    check_digit(0, 7'b0010010, 1'b1, "last_wins_d0");
    check_digit(3, 7'b0010010, 1'b1, "last_wins_d3");
    wait_pos(FRAME - 1);
    drive_load(16'h3333, 4'b0000);
    watch_one = 1'b0;
    check("never_showed_1", 16'(saw_one), 16'd0);
    check("commit_edge_fd", 16'(bus.frame_done), 16'd1);
    check_digit(0, 7'b0000110, 1'b1, "commit_edge_load_d0");

    // enable low for 5 cycles, pending still loads
    bus.enable = 1'b0;
    drive_load(16'h4444, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("disabled_out", 16'({bus.seg, bus.dp, bus.an, bus.frame_done}), 16'(OFF_OUT));
    end
    bus.enable = 1'b1;
    @(negedge clk);
    check("reenable_guard_an", 16'(bus.an), 16'hF);
    @(negedge clk);
    check("reenable_d0_an", 16'(bus.an), 16'hE);
    check("reenable_d0_seg", 16'(bus.seg), 16'h06);
    wait_commit();
    check_digit(0, 7'b1001100, 1'b1, "disabled_load_d0");

    // reset mid-slot on digit 2 discards pending
    wait_commit();
    drive_load(16'h5555, 4'b0000);
    begin
      bit found = 0;
      for (int i = 0; i < 64 && !found; i++) begin
        @(negedge clk);
        if (e_out.an == 4'b1011) found = 1;
      end
      if (!found) timeout_fail("wait_digit2");
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", 16'({bus.seg, bus.dp, bus.an, bus.frame_done}), 16'(OFF_OUT));
    @(negedge clk);
    rst_n = 1'b1;
    wait_commit();
    check_digit(1, 7'b0000001, 1'b1, "post_reset_d1");
    check_digit(3, 7'b0000001, 1'b1, "post_reset_d3");
    wait_commit();
    check_digit(2, 7'b0000001, 1'b1, "post_reset_d2");

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
